clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
Timekeeping controller for the board clock. It consumes the 1 Hz enable pulse from the prescaler and sequences cascaded seconds/minutes/hours modulo counting. It provides a button-driven set mode (hours, then minutes) and drives the display formatter with the current time and blink qualifiers.

Parameters:
SEC_MOD, 60, seconds modulus (count 0..SEC_MOD-1)
MIN_MOD, 60, minutes modulus
HOUR_MOD, 24, hours modulus
RESET_HOUR, 0, hour value loaded on reset (must be < HOUR_MOD)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
tick_1hz  input  1  single-cycle enable pulse, once per second
btn_mode  input  1  single-cycle pulse, already debounced/edge-detected
btn_inc  input  1  single-cycle pulse, already debounced/edge-detected
sec  output  6  current seconds, binary
min  output  6  current minutes, binary
hour  output  5  current hours, binary
set_hour  output  1  high while in SET_HOUR state
set_min  output  1  high while in SET_MIN state
blink  output  1  blink phase, toggles on each tick_1hz in set states
min_tick  output  1  one-cycle pulse when minutes roll 59->0 carry into hours (RUN only)

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, sec=0, min=0, hour=RESET_HOUR, blink=0, min_tick=0, set_hour=0, set_min=0.
- All outputs are registered and update on the rising edge of clk.
- FSM states: RUN, SET_HOUR, SET_MIN.
  - btn_mode: RUN->SET_HOUR->SET_MIN->RUN, one transition per pulse.
  - On the SET_MIN->RUN transition, sec is cleared to 0 in the same edge.
- RUN:
  - On tick_1hz, sec increments.
  - When sec=SEC_MOD-1: sec->0 and min increments.
  - When min=MIN_MOD-1 on that carry: min->0, hour increments, and min_tick=1 for that one cycle.
  - When hour=HOUR_MOD-1 on that carry: hour->0.
  - Full carry chain resolves in the single cycle of the tick (23:59:59 -> 00:00:00 in one edge).
  - btn_inc is ignored.
- SET_HOUR:
  - btn_inc: hour=(hour+1) mod HOUR_MOD. min and sec unchanged.
  - tick_1hz does not advance time; it toggles blink.
- SET_MIN:
  - btn_inc: min=(min+1) mod MIN_MOD. Never carries into hour.
  - tick_1hz toggles blink only.
- blink is forced to 0 in RUN and cleared on entry to SET_HOUR.
- set_hour and set_min are decoded from the state register and registered with it; they are never both 1.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode transition taken, inc dropped.
  - tick_1hz together with btn_mode in RUN: the tick is applied (time advances) and the state moves to SET_HOUR.
  - tick_1hz together with btn_mode in SET_MIN: the state moves to RUN with sec=0, and the tick is not applied.
- min_tick is 0 in all set states.
- Arithmetic uses compare-to-(MOD-1) then clear, never relying on natural binary overflow. Values must never leave 0..MOD-1.
- Reset asserted mid-set returns to RUN with reset values, discarding any edits.

Decomposition:
- Shared package clock_pkg holds:
  - state encoding (ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2)
  - default moduli
  - widths SEC_W=6, MIN_W=6, HOUR_W=5
- One natural sub-module: mod_counter_inc, a modulo counter with enable, active-low async reset, a synchronous clear, and a carry output. It is instantiated three times (sec/min/hour), and the FSM steers each instance's enable and clear.

Test Plan:
- Reset to 0, release, then 59 tick_1hz pulses -> sec=59, min=0. One more tick -> sec=0, min=1, min_tick=0 (minute carry alone does not pulse).
- Preload 23:59:59 via set mode, return to RUN, one tick -> hour=0, min=0, sec=0 in a single edge, min_tick=1 for exactly one cycle.
- btn_mode, then 25 btn_inc pulses in SET_HOUR -> hour=1 (wrap at 24), set_hour=1, set_min=0. Three tick_1hz pulses meanwhile -> blink=1, sec unchanged.
- SET_MIN at min=59, one btn_inc -> min=0, hour unchanged. Then btn_mode -> state RUN, sec=0, set_min=0, blink=0.
- btn_mode and btn_inc in the same cycle while in SET_HOUR at hour=5 -> state=SET_MIN, hour=5.
- Assert reset low for one cycle asynchronously, mid-cycle, while in SET_MIN with 12:34:xx -> immediately 00:00:00 (RESET_HOUR=0), RUN, all flags 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the board clock timekeeping slice: FSM encoding,
// counter widths and default moduli.
package clock_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int DEF_SEC_MOD  = 60;
    localparam int DEF_MIN_MOD  = 60;
    localparam int DEF_HOUR_MOD = 24;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_counter_inc.sv
// Modulo-MOD up counter with enable, synchronous clear (priority over enable)
// and a combinational carry that flags the wrap on the current enable.
module mod_counter_inc #(
    parameter int MOD     = 60,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);
    localparam logic [W-1:0] INIT = W'(RST_VAL);

    logic at_last;

    // Wrap by explicit compare so the count never depends on binary overflow.
    assign at_last = (cnt == LAST);
    assign carry   = en && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= INIT;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= at_last ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Board clock timekeeping: cascaded sec/min/hour counters driven by the 1 Hz
// enable, plus a button-driven set mode (hours, then minutes) with blink phase.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MOD    = DEF_SEC_MOD,
    parameter int MIN_MOD    = DEF_MIN_MOD,
    parameter int HOUR_MOD   = DEF_HOUR_MOD,
    parameter int RESET_HOUR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              set_hour,
    output logic              set_min,
    output logic              blink,
    output logic              min_tick
);

    state_t state_q, state_d;
    logic   sec_en, min_en, hour_en, sec_clr;
    logic   sec_carry, min_carry, hour_carry_unused;
    logic   blink_d, min_tick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            set_hour <= 1'b0;
            set_min  <= 1'b0;
            blink    <= 1'b0;
            min_tick <= 1'b0;
        end else begin
            state_q  <= state_d;
            set_hour <= (state_d == ST_SET_HOUR);
            set_min  <= (state_d == ST_SET_MIN);
            blink    <= blink_d;
            min_tick <= min_tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_en     = 1'b0;
        min_en     = 1'b0;
        hour_en    = 1'b0;
        sec_clr    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (btn_mode) state_d = ST_SET_HOUR;
                // A tick coinciding with btn_mode still advances time.
                sec_en  = tick_1hz;
                min_en  = sec_carry;
                hour_en = min_carry;
            end
            ST_SET_HOUR: begin
                if (btn_mode) state_d = ST_SET_MIN;
                hour_en = btn_inc && !btn_mode;
            end
            ST_SET_MIN: begin
                if (btn_mode) state_d = ST_RUN;
                min_en  = btn_inc && !btn_mode;
                sec_clr = btn_mode;
            end
            default: state_d = ST_RUN;
        endcase

        // Blink runs only while staying within the set states.
        if (state_q == ST_RUN || state_d == ST_RUN)
            blink_d = 1'b0;
        else if (tick_1hz)
            blink_d = !blink;
        else
            blink_d = blink;

        // min_carry can fire from btn_inc in SET_MIN; only a RUN rollover counts.
        min_tick_d = (state_q == ST_RUN) && min_carry;
    end

    mod_counter_inc #(.MOD(SEC_MOD), .W(SEC_W), .RST_VAL(0)) u_sec (
        .clk   (clk),
        .rst_n (reset),
        .en    (sec_en),
        .clr   (sec_clr),
        .cnt   (sec),
        .carry (sec_carry)
    );

    mod_counter_inc #(.MOD(MIN_MOD), .W(MIN_W), .RST_VAL(0)) u_min (
        .clk   (clk),
        .rst_n (reset),
        .en    (min_en),
        .clr   (1'b0),
        .cnt   (min),
        .carry (min_carry)
    );

    mod_counter_inc #(.MOD(HOUR_MOD), .W(HOUR_W), .RST_VAL(RESET_HOUR)) u_hour (
        .clk   (clk),
        .rst_n (reset),
        .en    (hour_en),
        .clr   (1'b0),
        .cnt   (hour),
        .carry (hour_carry_unused)
    );

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl; scenarios run in sequence
// and build on the time left by the previous one.
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, btn_mode, btn_inc;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       set_hour, set_min, blink, min_tick;

    int vectors    = 0;
    int miscompares = 0;

    clock_time_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .set_hour (set_hour),
        .set_min  (set_min),
        .blink    (blink),
        .min_tick (min_tick)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; one rising edge sees them, and the
    // task returns on the next falling edge where outputs are sampled.
    task automatic pulse(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick_1hz = t; btn_mode = m; btn_inc = i;
        @(negedge clk);
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({hour, min, sec} !== {5'd0, 6'd0, 6'd0}) begin
            miscompares++;
            $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", hour, min, sec);
        end
        vectors++;
        if ({set_hour, set_min, blink, min_tick} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0000", {set_hour, set_min, blink, min_tick});
        end
    endtask

    task automatic test_sec_rollover;
        repeat (59) pulse(1, 0, 0);
        vectors++;
        if ({min, sec} !== {6'd0, 6'd59}) begin
            miscompares++;
            $display("FAIL sec59 got %0d:%0d want 0:59", min, sec);
        end
        pulse(1, 0, 0);
        vectors++;
        if ({hour, min, sec, min_tick} !== {5'd0, 6'd1, 6'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL min_carry got %0d:%0d:%0d mt=%b want 0:1:0 mt=0", hour, min, sec, min_tick);
        end
        repeat (7) pulse(1, 0, 0);
        vectors++;
        if (sec !== 6'd7) begin
            miscompares++;
            $display("FAIL sec7 got %0d want 7", sec);
        end
    endtask

    task automatic test_set_hour_wrap;
        pulse(0, 1, 0);
        vectors++;
        if ({set_hour, set_min, blink} !== 3'b100) begin
            miscompares++;
            $display("FAIL enter_set_hour got %b want 100", {set_hour, set_min, blink});
        end
        for (int k = 0; k < 25; k++) begin
            pulse(0, 0, 1);
            if (k == 3 || k == 10 || k == 20) pulse(1, 0, 0);
        end
        vectors++;
        if ({hour, min, sec} !== {5'd1, 6'd1, 6'd7}) begin
            miscompares++;
            $display("FAIL hour_wrap got %0d:%0d:%0d want 1:1:7", hour, min, sec);
        end
        vectors++;
        if ({set_hour, set_min, blink} !== 3'b101) begin
            miscompares++;
            $display("FAIL set_hour_blink got %b want 101", {set_hour, set_min, blink});
        end
    endtask

    task automatic test_mode_inc_same;
        repeat (4) pulse(0, 0, 1);
        vectors++;
        if (hour !== 5'd5) begin
            miscompares++;
            $display("FAIL hour5 got %0d want 5", hour);
        end
        pulse(0, 1, 1);
        vectors++;
        if ({hour, min, set_hour, set_min} !== {5'd5, 6'd1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mode_inc got h=%0d m=%0d sh=%b sm=%b want h=5 m=1 sh=0 sm=1",
                     hour, min, set_hour, set_min);
        end
    endtask

    task automatic test_min_wrap;
        repeat (58) pulse(0, 0, 1);
        vectors++;
        if (min !== 6'd59) begin
            miscompares++;
            $display("FAIL min59 got %0d want 59", min);
        end
        pulse(0, 0, 1);
        vectors++;
        if ({hour, min} !== {5'd5, 6'd0}) begin
            miscompares++;
            $display("FAIL min_wrap got %0d:%0d want 5:0", hour, min);
        end
        pulse(0, 1, 0);
        vectors++;
        if ({sec, set_hour, set_min, blink} !== {6'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL exit_set got sec=%0d flags=%b want sec=0 flags=000",
                     sec, {set_hour, set_min, blink});
        end
    endtask

    task automatic test_full_carry;
        pulse(0, 1, 0);
        repeat (18) pulse(0, 0, 1);
        pulse(0, 1, 0);
        repeat (59) pulse(0, 0, 1);
        pulse(0, 1, 0);
        repeat (59) pulse(1, 0, 0);
        vectors++;
        if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
            miscompares++;
            $display("FAIL preload got %0d:%0d:%0d want 23:59:59", hour, min, sec);
        end
        pulse(1, 0, 0);
        vectors++;
        if ({hour, min, sec, min_tick} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL day_wrap got %0d:%0d:%0d mt=%b want 0:0:0 mt=1", hour, min, sec, min_tick);
        end
        @(negedge clk);
        vectors++;
        if (min_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL min_tick_width got %b want 0", min_tick);
        end
    endtask

    task automatic test_tick_with_mode;
        pulse(0, 0, 1);
        vectors++;
        if (hour !== 5'd0) begin
            miscompares++;
            $display("FAIL run_inc_ignored got hour=%0d want 0", hour);
        end
        pulse(1, 1, 0);
        vectors++;
        if ({sec, set_hour} !== {6'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL run_tick_mode got sec=%0d sh=%b want sec=1 sh=1", sec, set_hour);
        end
        pulse(0, 1, 0);
        pulse(1, 1, 0);
        vectors++;
        if ({sec, set_min, set_hour, blink, min} !== {6'd0, 3'b000, 6'd0}) begin
            miscompares++;
            $display("FAIL setmin_tick_mode got sec=%0d flags=%b want sec=0 flags=000",
                     sec, {set_min, set_hour, blink});
        end
    endtask

    task automatic test_async_reset;
        repeat (3) pulse(1, 0, 0);
        pulse(0, 1, 0);
        repeat (12) pulse(0, 0, 1);
        pulse(0, 1, 0);
        repeat (34) pulse(0, 0, 1);
        vectors++;
        if ({hour, min, sec, set_min} !== {5'd12, 6'd34, 6'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset got %0d:%0d:%0d sm=%b want 12:34:3 sm=1", hour, min, sec, set_min);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({hour, min, sec, set_hour, set_min, blink, min_tick} !== {5'd0, 6'd0, 6'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL async_reset got %0d:%0d:%0d flags=%b want 0:0:0 flags=0000",
                     hour, min, sec, {set_hour, set_min, blink, min_tick});
        end
        @(negedge clk);
        reset = 1'b1;
        pulse(1, 0, 0);
        vectors++;
        if ({sec, set_hour, set_min} !== {6'd1, 2'b00}) begin
            miscompares++;
            $display("FAIL post_reset_run got sec=%0d sh=%b sm=%b want sec=1 run", sec, set_hour, set_min);
        end
    endtask

    initial begin
        test_reset();
        test_sec_rollover();
        test_set_hour_wrap();
        test_mode_inc_same();
        test_min_wrap();
        test_full_carry();
        test_tick_with_mode();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
